std_seq_ctrl: RTL and testbench
===============================

// Module: std_seq_ctrl
// PURPOSE
//   Go/done initiator: drives the go inputs of N_STEPS go/done components
//   (std_reg write_en/done style) strictly in order. It waits for each step's
//   done before issuing the next step.
//   Sits between a parent control FSM (its own go/done) and the datapath
//   cells it sequences. Lets generated user designs chain registered stages
//   without hand-written control.
// PARAMETERS
//   N_STEPS  4    number of sequenced steps, >= 1
//   TIMEOUT  255  max cycles per step before error (SEQ_WATCHDOG_EN only), >= 1
// PORTS
//   clk        in   1              rising-edge clock
//   reset      in   1              async, active-low reset
//   go         in   1              start/hold request from parent; level, held until done
//   done       out  1              1-cycle pulse: all steps completed
//   step_go    out  N_STEPS        one-hot go to step i (to component write_en/go)
//   step_done  in   N_STEPS        done from step i (component done)
//   busy       out  1              high in RUN
//   cur_step   out  $clog2(N_STEPS) (min 1)  index of active step
//   error      out  1              watchdog expiry flag (tied 0 without macro)
// BEHAVIOUR
//   - Reset (reset=0, async): state=IDLE, step_go=0, done=0, busy=0,
//     cur_step=0, error=0. All outputs are registered.
//   - FSM states: IDLE, RUN, DONE (+ ERR with macro).
//     - IDLE: go=1 sampled -> RUN, cur_step=0, step_go=1<<0.
//     - RUN:
//       - step_done[cur_step]=1 sampled and cur_step<N_STEPS-1 -> cur_step+1,
//         one-hot step_go moves to the new step on the same edge.
//       - step_done[cur_step]=1 with cur_step=N_STEPS-1 -> DONE, step_go=0.
//     - DONE: done=1 for exactly one cycle -> IDLE.
//   - step_go is never zero in RUN and never has more than one bit set.
//   - step_done bits of inactive steps are ignored, even if high.
//   - Latency: go high to step_go[0] is 1 cycle. Each step occupies
//     max(1, component latency + 1) cycles. std_reg steps take 2 cycles.
//     Last step_done to done is 1 cycle.
//   - Abort: go=0 sampled in RUN -> IDLE next edge, step_go=0, no done pulse.
//   - Restart: go still high in IDLE after DONE -> new run starts (back-to-back).
//     go in DONE is ignored.
//   - N_STEPS=1: RUN holds step 0 only; cur_step is 1 bit, constant 0.
//   - Reset mid-run: immediate async return to reset values; no done.
// CONFIGURATION
//   SEQ_WATCHDOG_EN defined:
//     - A per-step cycle counter (width $clog2(TIMEOUT+1)) clears on every
//       step entry.
//     - If the counter reaches TIMEOUT while in RUN with no step_done ->
//       ERR: step_go=0, busy=0, error=1.
//     - ERR is held until go=0 is sampled, then IDLE with error=0.
//     - No done pulse is issued from ERR.
//   SEQ_WATCHDOG_EN undefined:
//     - No counter and no ERR state; RUN waits indefinitely.
//     - error is constant 0 and TIMEOUT is unused.
// TESTING
//   1 Reset: hold reset=0 for 3 cycles with go=1 -> all outputs 0; release ->
//     step_go=4'b0001 one cycle after go is sampled.
//   2 Chain of 4 std_reg models (done 1 cycle after go) -> step_go sequence
//     0001,0010,0100,1000 at 2 cycles each; done pulse at cycle 9 after go;
//     busy high for 8 cycles.
//   3 Spurious step_done=4'b1110 during step 0 -> cur_step stays 0 until
//     step_done[0]=1.
//   4 Drop go during step 2 -> next cycle step_go=0, busy=0, no done; raise go
//     -> restarts at step 0.
//   5 go held high across DONE -> done pulses once, then step_go=0001 again on
//     the cycle after IDLE.
//   6 [SEQ_WATCHDOG_EN, TIMEOUT=5] step 1 never done -> error=1 after 5 cycles
//     in step 1, step_go=0; go=0 -> error clears in 1 cycle.

Source files
------------

// File: rtl/std_seq_ctrl.sv
// Go/done sequencer: issues one-hot go to N_STEPS components in order.
// Define SEQ_WATCHDOG_EN to add a per-step timeout that parks in an error state.
module std_seq_ctrl #(
    parameter int N_STEPS = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    output logic               done,
    output logic [N_STEPS-1:0] step_go,
    input  logic [N_STEPS-1:0] step_done,
    output logic               busy,
    output logic [(N_STEPS > 1 ? $clog2(N_STEPS) : 1)-1:0] cur_step,
    output logic               error
);

    localparam int CW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cur_q, cur_d;
    logic [N_STEPS-1:0] step_go_q, step_go_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               act_done;
    logic               last;
    logic               wd_hit;

    // step_go_q is one-hot on the active step, so masking ignores stale dones
    assign act_done = |(step_done & step_go_q);
    assign last     = (cur_q == CW'(N_STEPS - 1));

`ifdef SEQ_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wd_q, wd_d;

    assign wd_hit = (wd_q == TW'(TIMEOUT - 1));

    always_comb begin
        wd_d = '0;
        if (state_q == S_RUN && !act_done) begin
            wd_d = wd_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT;
    assign wd_hit         = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            step_go_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            step_go_q <= step_go_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    // Abort on go=0 takes priority over a coincident step_done
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (go) state_d = S_RUN;
            end
            S_RUN: begin
                if (!go) begin
                    state_d = S_IDLE;
                end else if (act_done && last) begin
                    state_d = S_DONE;
                end else if (!act_done && wd_hit) begin
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                if (!go) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cur_d     = '0;
        step_go_d = '0;
        done_d    = 1'b0;
        busy_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_d)
            S_RUN: begin
                busy_d = 1'b1;
                if (state_q == S_RUN) begin
                    cur_d = act_done ? cur_q + CW'(1) : cur_q;
                end
                for (int i = 0; i < N_STEPS; i++) begin
                    step_go_d[i] = (cur_d == CW'(i));
                end
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            S_ERR: begin
                err_d = 1'b1;
            end
            default: begin
                cur_d = '0;
            end
        endcase
    end

    assign done     = done_q;
    assign step_go  = step_go_q;
    assign busy     = busy_q;
    assign cur_step = cur_q;
    assign error    = err_q;

endmodule

// File: tb/tb_std_seq_ctrl.sv
// Bench for std_seq_ctrl: vector table, directed corner sequences and
// randomized traffic against a step-index reference model.
module tb_std_seq_ctrl;

    localparam int N  = 4;
    localparam int TO = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic         go;
    logic [N-1:0] step_done;
    logic [N-1:0] step_go;
    logic         done;
    logic         busy;
    logic         error;
    logic [1:0]   cur_step;

    always #5 clk = ~clk;

    std_seq_ctrl #(
        .N_STEPS(N),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .done     (done),
        .step_go  (step_go),
        .step_done(step_done),
        .busy     (busy),
        .cur_step (cur_step),
        .error    (error)
    );

    typedef struct {
        logic         g;
        logic [N-1:0] sd;
        logic [N-1:0] sg;
        logic         d;
        logic         b;
        logic [1:0]   cs;
    } vec_t;

    vec_t tbl[13];
    int   n_chk  = 0;
    int   n_fail = 0;

    // reference model: active flag, step index, wait counter
    bit           m_act;
    bit           m_fin;
    bit           m_err;
    int           m_step;
    int           m_wait;
    logic [N-1:0] regs;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        m_act  = 1'b0;
        m_fin  = 1'b0;
        m_err  = 1'b0;
        m_step = 0;
        m_wait = 0;
        regs   = '0;
    endtask

    function automatic logic [N-1:0] exp_sg();
        logic [N-1:0] one;
        one = 1;
        return m_act ? (one << m_step) : '0;
    endfunction

    task automatic m_update(input logic g, input logic [N-1:0] sd);
        if (m_fin) begin
            m_fin = 1'b0;
        end else if (m_err) begin
            if (!g) m_err = 1'b0;
        end else if (!m_act) begin
            if (g) begin
                m_act  = 1'b1;
                m_step = 0;
                m_wait = 0;
            end
        end else if (!g) begin
            m_act = 1'b0;
        end else if (sd[m_step]) begin
            m_wait = 0;
            if (m_step == N - 1) begin
                m_act = 1'b0;
                m_fin = 1'b1;
            end else begin
                m_step++;
            end
        end else begin
            m_wait++;
`ifdef SEQ_WATCHDOG_EN
            if (m_wait >= TO) begin
                m_act = 1'b0;
                m_err = 1'b1;
            end
`endif
        end
    endtask

    task automatic tick();
        logic [N-1:0] pre;
        pre = exp_sg();
        @(posedge clk);
        if (!reset) begin
            m_reset();
        end else begin
            m_update(go, step_done);
            regs = pre;
        end
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".step_go"}, 32'(step_go), 32'(exp_sg()));
        chk({tag, ".done"}, 32'(done), 32'(m_fin));
        chk({tag, ".busy"}, 32'(busy), 32'(m_act));
        chk({tag, ".error"}, 32'(error), 32'(m_err));
        if (m_act) chk({tag, ".cur_step"}, 32'(cur_step), 32'(m_step));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".step_go"}, 32'(step_go), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".cur_step"}, 32'(cur_step), 0);
        chk({tag, ".error"}, 32'(error), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1);
    end

    initial begin
        int           first_sg;
        int           done_at;
        int           busy_n;
        int           t1;
        int           terr;
        int           mode;
        logic [N-1:0] sgs[32];

        //        go    step_done  step_go  done  busy  cur
        tbl[0]  = '{1'b1, 4'b0000, 4'b0001, 1'b0, 1'b1, 2'd0};
        tbl[1]  = '{1'b1, 4'b1110, 4'b0001, 1'b0, 1'b1, 2'd0};
        tbl[2]  = '{1'b1, 4'b1110, 4'b0001, 1'b0, 1'b1, 2'd0};
        tbl[3]  = '{1'b1, 4'b0001, 4'b0010, 1'b0, 1'b1, 2'd1};
        tbl[4]  = '{1'b1, 4'b0001, 4'b0010, 1'b0, 1'b1, 2'd1};
        tbl[5]  = '{1'b1, 4'b0010, 4'b0100, 1'b0, 1'b1, 2'd2};
        tbl[6]  = '{1'b1, 4'b0100, 4'b1000, 1'b0, 1'b1, 2'd3};
        tbl[7]  = '{1'b1, 4'b0111, 4'b1000, 1'b0, 1'b1, 2'd3};
        tbl[8]  = '{1'b1, 4'b1000, 4'b0000, 1'b1, 1'b0, 2'd0};
        tbl[9]  = '{1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[10] = '{1'b1, 4'b0000, 4'b0001, 1'b0, 1'b1, 2'd0};
        tbl[11] = '{1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[12] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};

        reset     = 1'b0;
        go        = 1'b1;
        step_done = '0;
        m_reset();
        repeat (3) begin
            tick();
            chk_zero("reset_hold");
        end
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            go        = tbl[i].g;
            step_done = tbl[i].sd;
            tick();
            chk($sformatf("tbl%0d.step_go", i), 32'(step_go), 32'(tbl[i].sg));
            chk($sformatf("tbl%0d.done", i), 32'(done), 32'(tbl[i].d));
            chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].b));
            if (tbl[i].b) begin
                chk($sformatf("tbl%0d.cur", i), 32'(cur_step), 32'(tbl[i].cs));
            end
            chk($sformatf("tbl%0d.error", i), 32'(error), 0);
        end

        // chain of std_reg components
        go       = 1'b1;
        first_sg = -1;
        done_at  = -1;
        busy_n   = 0;
        for (int t = 1; t <= 20 && done_at < 0; t++) begin
            step_done = regs;
            tick();
            cmp_model("chain");
            sgs[t] = step_go;
            if (first_sg < 0 && step_go != '0) first_sg = t;
            if (busy) busy_n++;
            if (done) done_at = t;
        end
        chk("chain.first_go", 32'(first_sg), 1);
        chk("chain.done_cycle", 32'(done_at), 9);
        chk("chain.busy_cycles", 32'(busy_n), 8);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("chain.seq%0d", 2 * k + 1), 32'(sgs[2 * k + 1]), 32'(1 << k));
            chk($sformatf("chain.seq%0d", 2 * k + 2), 32'(sgs[2 * k + 2]), 32'(1 << k));
        end

        // go held across DONE: idle one cycle then restart
        step_done = regs;
        tick();
        chk("restart.idle_sg", 32'(step_go), 0);
        chk("restart.idle_done", 32'(done), 0);
        step_done = regs;
        tick();
        chk("restart.sg", 32'(step_go), 1);
        chk("restart.busy", 32'(busy), 1);

        // abort during step 2
        for (int t = 0; t < 10 && !(busy && cur_step == 2'd2); t++) begin
            step_done = regs;
            tick();
            cmp_model("to_step2");
        end
        chk("abort.reached_step2", 32'(cur_step), 2);
        go        = 1'b0;
        step_done = regs;
        tick();
        chk("abort.sg", 32'(step_go), 0);
        chk("abort.busy", 32'(busy), 0);
        chk("abort.done", 32'(done), 0);
        repeat (3) begin
            step_done = '0;
            tick();
            chk("abort.no_done", 32'(done), 0);
        end
        go = 1'b1;
        tick();
        chk("abort.restart_sg", 32'(step_go), 1);
        chk("abort.restart_cur", 32'(cur_step), 0);
        go = 1'b0;
        tick();

`ifdef SEQ_WATCHDOG_EN
        // step 1 never completes
        go   = 1'b1;
        t1   = -1;
        terr = -1;
        for (int t = 1; t <= 30 && terr < 0; t++) begin
            step_done = regs & 4'b0001;
            tick();
            cmp_model("wdog");
            if (t1 < 0 && step_go == 4'b0010) t1 = t;
            if (error) terr = t;
        end
        chk("wdog.cycles", 32'(terr - t1), TO);
        chk("wdog.sg", 32'(step_go), 0);
        chk("wdog.busy", 32'(busy), 0);
        go = 1'b0;
        tick();
        chk("wdog.clear", 32'(error), 0);
`else
        t1   = 0;
        terr = 0;
`endif

        // async reset mid-run
        go = 1'b1;
        repeat (3) begin
            step_done = regs;
            tick();
        end
        chk("midrst.running", 32'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        m_reset();
        chk_zero("midrst.async");
        tick();
        chk_zero("midrst.held");
        reset = 1'b1;
        go    = 1'b0;
        tick();

        // randomized traffic against the model
        mode = 0;
        for (int c = 0; c < 1500; c++) begin
            if (c % 150 == 0) mode = $urandom_range(0, 2);
            go = ($urandom_range(0, 19) != 0);
            unique case (mode)
                0: step_done = regs;
                1: step_done = 4'($urandom);
                default: step_done = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '0;
            endcase
            tick();
            cmp_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
